// File: rtl/div_issue_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : div_issue_ctrl                                                |
// | Purpose  : EX-stage issue/commit controller for an iterative divider;    |
// |            owns the HI/LO registers. Optional: DIV_ZERO_BYPASS_EN.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module div_issue_ctrl #(
  parameter int WIDTH        = 32,
  parameter int START_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_start,
  output logic             div_symbol,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [1:0] START_LAST = 2'(START_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       start_cnt_q, start_cnt_d;
  logic             div_start_q, div_start_d;
  logic             div_symbol_q, div_symbol_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] q_buf_q, q_buf_d;
  logic [WIDTH-1:0] r_buf_q, r_buf_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             seen_busy_q, seen_busy_d;
  logic             accept;
  logic             bypass;

  assign accept = req_valid & ~flush;

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = (req_b == '0);
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    start_cnt_d  = start_cnt_q;
    div_start_d  = div_start_q;
    div_symbol_d = div_symbol_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    q_buf_d      = q_buf_q;
    r_buf_d      = r_buf_q;
    seen_busy_d  = seen_busy_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    stall        = 1'b0;
    done         = 1'b0;

    // MTHI/MTLO by default; a committing result overrides below.
    if (hi_we) hi_d = wdata;
    if (lo_we) lo_d = wdata;

    case (state_q)
      ST_IDLE: begin
        stall = accept;
        if (accept) begin
          div_a_d      = req_a;
          div_b_d      = req_b;
          div_symbol_d = req_signed;
          if (bypass) begin
            q_buf_d = '1;
            r_buf_d = req_a;
            state_d = ST_DONE;
          end else begin
            div_start_d = 1'b1;
            start_cnt_d = 2'd0;
            seen_busy_d = 1'b0;
            state_d     = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        stall = 1'b1;
        if (flush) begin
          div_start_d = 1'b0;
          state_d     = ST_DRAIN;
        end else if (start_cnt_q == START_LAST) begin
          div_start_d = 1'b0;
          seen_busy_d = 1'b0;
          state_d     = ST_WAIT;
        end else begin
          start_cnt_d = start_cnt_q + 2'd1;
        end
      end
      ST_WAIT: begin
        stall       = 1'b1;
        seen_busy_d = seen_busy_q | div_busy;
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (seen_busy_q && !div_busy) begin
          q_buf_d = div_q;
          r_buf_d = div_r;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (!flush) begin
          lo_d = q_buf_q;
          hi_d = r_buf_q;
        end
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        // Cancelled divide still runs to completion before a new issue.
        stall       = req_valid;
        seen_busy_d = seen_busy_q | div_busy;
        if (seen_busy_q && !div_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      start_cnt_q  <= 2'd0;
      div_start_q  <= 1'b0;
      div_symbol_q <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      q_buf_q      <= '0;
      r_buf_q      <= '0;
      seen_busy_q  <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      start_cnt_q  <= start_cnt_d;
      div_start_q  <= div_start_d;
      div_symbol_q <= div_symbol_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      q_buf_q      <= q_buf_d;
      r_buf_q      <= r_buf_d;
      seen_busy_q  <= seen_busy_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign div_start  = div_start_q;
  assign div_symbol = div_symbol_q;
  assign div_a      = div_a_q;
  assign div_b      = div_b_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule
`default_nettype wire
